bandai_fcg_core: RTL and testbench
==================================

# bandai_fcg_core

Parametrised Bandai FCG-family mapper core covering FCG-1/2, LZ93D50 and LZ93D50 with PRG-RAM and outer PRG bank in one block, selected by `MODE`. It decodes CPU register writes, produces PRG/CHR/CIRAM addressing and runs the M2-cycle IRQ down-counter. It also exposes save-state read/write access. It sits between the bus decode and the cartridge memory address outputs, alongside the other per-mapper modules.

## Interface
- `MODE`, default 1: 0 = FCG-1/2, 1 = LZ93D50, 2 = LZ93D50 + SRAM + outer bank.
- `PRG_W`, default 4: width of the inner PRG bank register.
- `IRQ_W`, default 16: IRQ counter and latch width, legal range 9..16.
- `m2`, input, 1: system clock. All state updates on the falling edge.
- `map_rst_n`, input, 1: asynchronous, active-low reset.
- `cpu_addr`, input, 16: CPU address.
- `cpu_dat`, input, 8: CPU write data, also used as save-state write data.
- `cpu_rw`, input, 1: 1 = read, 0 = write.
- `ppu_addr`, input, 14: PPU address.
- `ss_act`, input, 1: save-state access active.
- `ss_we`, input, 1: save-state write strobe.
- `ss_addr`, input, 8: save-state register index.
- `prg_addr`, output, PRG_W+15: PRG ROM address.
- `chr_addr`, output, 18: CHR address.
- `ciram_a10`, output, 1: nametable select.
- `ram_ce`, output, 1: PRG-RAM select.
- `irq`, output, 1: IRQ request, active-high, registered.
- `ss_rdat`, output, 8: save-state readback.

## Operation
- **Register window**
  - MODE 0: $6000–$7FFF.
  - MODE 1/2: $8000–$FFFF.
  - The register index is `cpu_addr[3:0]`. A write is any `!cpu_rw` cycle inside the window.
- **Register map**
  - 0–7: `chr[n]` (8-bit).
  - 8: `prg[PRG_W-1:0]`.
  - 9: `mirror[1:0]`.
  - A: `irq_on <= d[0]`; `irq_pend <= 0`. MODE 1/2 also loads `ctr <= latch`.
  - B: low byte. MODE 0 writes `ctr[7:0]`; MODE 1/2 writes `latch[7:0]`.
  - C: high byte. MODE 0 writes `ctr[IRQ_W-1:8]`; MODE 1/2 writes `latch[IRQ_W-1:8]`.
  - D: MODE 2 only, `ram_on <= d[5]`. Ignored in other modes.
- **Counter**
  - While `irq_on`, the counter decrements by 1 each cycle and wraps from 0 to all-ones.
  - If `ctr == 0` while `irq_on`, `irq_pend` sets on that edge.
  - `irq = irq_pend`. It stays set until a register-A write or reset.
- **Write precedence**
  - A register-A write in the same cycle as a zero count: the write wins, so `pend = 0` and the reload applies.
  - MODE 0 byte write during counting: the written byte takes the new value, the other byte holds its pre-decrement value, and no decrement happens that cycle.
- **PRG**
  - `prg_addr[13:0] = cpu_addr[13:0]`.
  - Bank field = `cpu_addr[14] ? all-ones : prg`.
  - `prg_addr[PRG_W+14]` = OR of `chr[0..3][0]` in MODE 2, else 0.
- **CHR**
  - MODE 0/1: `chr_addr = {chr[ppu_addr[12:10]], ppu_addr[9:0]}`.
  - MODE 2: `chr_addr = {5'b0, ppu_addr[12:0]}` (8 KB CHR-RAM).
- **Mirroring (`ciram_a10`)**
  - 0: `ppu_addr[10]`.
  - 1: `ppu_addr[11]`.
  - 2: 0.
  - 3: 1.
- **PRG-RAM:** `ram_ce = (MODE == 2) & ram_on & cpu_addr[15:13] == 3'b011`.
- **Save state**
  - While `ss_act`, the save-state path has absolute priority and normal register writes and counting are frozen.
  - Index map:
    - 0–7: `chr`.
    - 8: `prg`.
    - 9: `ctr` high byte.
    - 10: `ctr` low byte.
    - 11: `latch` high byte.
    - 12: `latch` low byte.
    - 13: `{ram_on, irq_on, irq_pend, mirror}` in bits [4:0].
  - Bytes are zero-extended on read. Unmapped indices read $FF.
  - `ss_we` writes the same fields from `cpu_dat`.

## Timing
- **Reset:** asynchronous assert clears `chr`, `prg`, `mirror`, `ctr`, `latch`, `irq_on`, `irq_pend` and `ram_on` to 0, so `irq = 0` immediately.
- **Reset mid-count:** the counter stops and `irq` drops without waiting for an `m2` edge.
- **Write latency:** a register write takes effect at the falling `m2` edge of the write cycle. Address outputs reflect the new value combinationally after that edge.
- **IRQ latency:** `irq` rises at the falling edge where the counter was 0, i.e. N+1 enabled cycles after loading value N.
- **Unaffected by `irq_on`:** address outputs depend on registers and live bus inputs only.

## Structure
- **Package `bandai_pkg`:**
  - Mode constants `BFCG_FCG`, `BFCG_LZ`, `BFCG_LZ_SRAM`.
  - Register index constants `REG_PRG`, `REG_MIR`, `REG_IRQ_CTL`, `REG_IRQ_LO`, `REG_IRQ_HI`, `REG_RAM`.
  - Save-state index constants.
  - Mirror encoding.
- **Sub-module `bandai_irq_ctr`:** owns the counter, latch, pending flag, precedence rules and save-state access to them. It is parametrised by `IRQ_W` and a direct-versus-latched load select.

## Test plan
- **MODE 1 latch/reload:** write B=$03, C=$00, then A=$01 → `irq` rises on the 4th following `m2` falling edge. Writing A=$00 then clears `irq`.
- **MODE 0 direct load:** write $600B=$02, $600C=$00, $600A=$01 → `ctr` reads 2, then 1, then 0. `irq` sets on the next edge, and `ctr` wraps to $FFFF.
- **Precedence:** with `ctr = 0` and `irq_on = 1`, write A=$01 in the same cycle → `irq` stays 0 and `ctr = latch`.
- **MODE 2 banking:**
  - `chr[2] = $01`, `prg = $05` → `$8000` maps to `prg_addr` bits[18:14] = $15 and `$C000` maps to $1F.
  - `$xxxD = $20` → `ram_ce` goes high at `$6000`.
  - Mirror = 1 → `ciram_a10` follows `ppu_addr[11]`.
- **Save state:** with `ss_act`, write index 13 = $1C and index 9 = $12 → readback gives $1C and $12, no counting occurs, and index 200 reads $FF.
- **Async reset mid-count:** drop `map_rst_n` between `m2` edges → `irq` and all registers read 0 before the next edge.

Source files
------------

// File: rtl/bandai_pkg.sv
// Shared constants for the Bandai FCG-family mapper: modes, register and save-state indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bandai_pkg;

    localparam int BFCG_FCG     = 0;
    localparam int BFCG_LZ      = 1;
    localparam int BFCG_LZ_SRAM = 2;

    localparam logic [3:0] REG_PRG     = 4'h8;
    localparam logic [3:0] REG_MIR     = 4'h9;
    localparam logic [3:0] REG_IRQ_CTL = 4'hA;
    localparam logic [3:0] REG_IRQ_LO  = 4'hB;
    localparam logic [3:0] REG_IRQ_HI  = 4'hC;
    localparam logic [3:0] REG_RAM     = 4'hD;

    localparam logic [7:0] SS_PRG    = 8'd8;
    localparam logic [7:0] SS_CTR_HI = 8'd9;
    localparam logic [7:0] SS_CTR_LO = 8'd10;
    localparam logic [7:0] SS_LAT_HI = 8'd11;
    localparam logic [7:0] SS_LAT_LO = 8'd12;
    localparam logic [7:0] SS_FLAGS  = 8'd13;

    typedef enum logic [1:0] {
        MIR_V = 2'd0,
        MIR_H = 2'd1,
        MIR_0 = 2'd2,
        MIR_1 = 2'd3
    } mirror_t;

    // FCG-1/2 decodes its registers at $6000-$7FFF, the LZ93D50 parts at $8000-$FFFF.
    function automatic logic in_reg_window(input int mode, input logic [15:0] a);
        return (mode == BFCG_FCG) ? (a[15:13] == 3'b011) : a[15];
    endfunction

endpackage

// File: rtl/bandai_irq_ctr.sv
// IRQ down-counter with optional reload latch, pending flag and save-state access.
// Latency: register writes and counting take effect on the falling m2 edge; irq_pend is a flop.
// Backpressure: none; strobes are accepted every cycle, save-state access freezes the counter.
module bandai_irq_ctr #(
    parameter int IRQ_W   = 16,
    parameter bit LATCHED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_ctl,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [7:0]       dat,
    input  logic             ss_act,
    input  logic             ss_we,
    input  logic [7:0]       ss_addr,
    output logic [IRQ_W-1:0] ctr,
    output logic [IRQ_W-1:0] latch,
    output logic             irq_on,
    output logic             irq_pend
);
    import bandai_pkg::*;

    localparam logic [IRQ_W-1:0] ONE = {{(IRQ_W-1){1'b0}}, 1'b1};

    logic [IRQ_W-1:0] ctr_nxt;
    logic [IRQ_W-1:0] latch_nxt;
    logic             on_nxt;
    logic             pend_nxt;

    // Next state: count first, then let register writes override it (writes win).
    always_comb begin
        ctr_nxt   = ctr;
        latch_nxt = latch;
        on_nxt    = irq_on;
        pend_nxt  = irq_pend;
        if (irq_on) begin
            ctr_nxt = ctr - ONE;
            if (ctr == '0) pend_nxt = 1'b1;
        end
        // A direct byte write suppresses that cycle's decrement; the other byte keeps its old value.
        if (wr_lo) begin
            if (LATCHED) latch_nxt[7:0] = dat;
            else begin
                ctr_nxt      = ctr;
                ctr_nxt[7:0] = dat;
            end
        end
        if (wr_hi) begin
            if (LATCHED) latch_nxt[IRQ_W-1:8] = dat[IRQ_W-9:0];
            else begin
                ctr_nxt            = ctr;
                ctr_nxt[IRQ_W-1:8] = dat[IRQ_W-9:0];
            end
        end
        if (wr_ctl) begin
            on_nxt   = dat[0];
            pend_nxt = 1'b0;
            if (LATCHED) ctr_nxt = latch;
        end
    end

    // State register; save-state access has priority and freezes normal updates.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr      <= '0;
            latch    <= '0;
            irq_on   <= 1'b0;
            irq_pend <= 1'b0;
        end else if (ss_act) begin
            if (ss_we) begin
                case (ss_addr)
                    SS_CTR_HI: ctr[IRQ_W-1:8]   <= dat[IRQ_W-9:0];
                    SS_CTR_LO: ctr[7:0]         <= dat;
                    SS_LAT_HI: latch[IRQ_W-1:8] <= dat[IRQ_W-9:0];
                    SS_LAT_LO: latch[7:0]       <= dat;
                    SS_FLAGS: begin
                        irq_on   <= dat[3];
                        irq_pend <= dat[2];
                    end
                    default: ;
                endcase
            end
        end else begin
            ctr      <= ctr_nxt;
            latch    <= latch_nxt;
            irq_on   <= on_nxt;
            irq_pend <= pend_nxt;
        end
    end

endmodule

// File: rtl/bandai_fcg_core.sv
// Bandai FCG-1/2 / LZ93D50 mapper: register decode, PRG/CHR/CIRAM addressing, IRQ, save state.
// Latency: register writes land on the falling m2 edge; address outputs are combinational.
// Backpressure: none; every in-window write cycle is taken, save-state access freezes the core.
module bandai_fcg_core #(
    parameter int MODE  = 1,
    parameter int PRG_W = 4,
    parameter int IRQ_W = 16
) (
    input  logic              m2,
    input  logic              map_rst_n,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_dat,
    input  logic              cpu_rw,
    input  logic [13:0]       ppu_addr,
    input  logic              ss_act,
    input  logic              ss_we,
    input  logic [7:0]        ss_addr,
    output logic [PRG_W+14:0] prg_addr,
    output logic [17:0]       chr_addr,
    output logic              ciram_a10,
    output logic              ram_ce,
    output logic              irq,
    output logic [7:0]        ss_rdat
);
    import bandai_pkg::*;

    logic [7:0]       chr [8];
    logic [PRG_W-1:0] prg;
    mirror_t          mirror;
    logic             ram_on;
    logic [IRQ_W-1:0] ctr;
    logic [IRQ_W-1:0] latch;
    logic             irq_on;
    logic             irq_pend;

    logic [3:0]       idx;
    logic             reg_wr;
    logic [PRG_W-1:0] bank;
    logic             outer;
    logic             unused_bits;

    assign idx         = cpu_addr[3:0];
    assign reg_wr      = !cpu_rw && in_reg_window(MODE, cpu_addr) && !ss_act;
    assign unused_bits = ppu_addr[13];

    bandai_irq_ctr #(
        .IRQ_W   (IRQ_W),
        .LATCHED (MODE != BFCG_FCG)
    ) u_irq (
        .clk      (m2),
        .rst_n    (map_rst_n),
        .wr_ctl   (reg_wr && idx == REG_IRQ_CTL),
        .wr_lo    (reg_wr && idx == REG_IRQ_LO),
        .wr_hi    (reg_wr && idx == REG_IRQ_HI),
        .dat      (cpu_dat),
        .ss_act   (ss_act),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .ctr      (ctr),
        .latch    (latch),
        .irq_on   (irq_on),
        .irq_pend (irq_pend)
    );

    assign irq = irq_pend;

    // Banking registers: save-state writes first, then CPU register writes.
    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            for (int i = 0; i < 8; i++) chr[i] <= '0;
            prg    <= '0;
            mirror <= MIR_V;
            ram_on <= 1'b0;
        end else if (ss_act) begin
            if (ss_we) begin
                if (ss_addr < 8'd8) chr[ss_addr[2:0]] <= cpu_dat;
                else if (ss_addr == SS_PRG) prg <= cpu_dat[PRG_W-1:0];
                else if (ss_addr == SS_FLAGS) begin
                    ram_on <= cpu_dat[4];
                    mirror <= mirror_t'(cpu_dat[1:0]);
                end
            end
        end else if (reg_wr) begin
            if (!idx[3]) chr[idx[2:0]] <= cpu_dat;
            else begin
                case (idx)
                    REG_PRG: prg    <= cpu_dat[PRG_W-1:0];
                    REG_MIR: mirror <= mirror_t'(cpu_dat[1:0]);
                    REG_RAM: if (MODE == BFCG_LZ_SRAM) ram_on <= cpu_dat[5];
                    default: ;
                endcase
            end
        end
    end

    // PRG: upper 16 KB fixed to the last bank; the SRAM board adds an outer bank bit from CHR regs.
    assign bank     = cpu_addr[14] ? '1 : prg;
    assign outer    = (MODE == BFCG_LZ_SRAM) && (chr[0][0] | chr[1][0] | chr[2][0] | chr[3][0]);
    assign prg_addr = {outer, bank, cpu_addr[13:0]};
    assign ram_ce   = (MODE == BFCG_LZ_SRAM) && ram_on && (cpu_addr[15:13] == 3'b011);

    // CHR: 1 KB banks from the CHR registers, or a flat 8 KB CHR-RAM on the SRAM board.
    always_comb begin
        if (MODE == BFCG_LZ_SRAM) chr_addr = {5'b0, ppu_addr[12:0]};
        else                      chr_addr = {chr[ppu_addr[12:10]], ppu_addr[9:0]};
    end

    // Nametable select from the mirroring register.
    always_comb begin
        case (mirror)
            MIR_V:   ciram_a10 = ppu_addr[10];
            MIR_H:   ciram_a10 = ppu_addr[11];
            MIR_0:   ciram_a10 = 1'b0;
            default: ciram_a10 = 1'b1;
        endcase
    end

    // Save-state readback: narrow fields zero-extended, unmapped indices read $FF.
    always_comb begin
        ss_rdat = 8'hFF;
        if (ss_addr < 8'd8) ss_rdat = chr[ss_addr[2:0]];
        else begin
            case (ss_addr)
                SS_PRG: begin
                    ss_rdat = '0;
                    ss_rdat[PRG_W-1:0] = prg;
                end
                SS_CTR_HI: begin
                    ss_rdat = '0;
                    ss_rdat[IRQ_W-9:0] = ctr[IRQ_W-1:8];
                end
                SS_CTR_LO: ss_rdat = ctr[7:0];
                SS_LAT_HI: begin
                    ss_rdat = '0;
                    ss_rdat[IRQ_W-9:0] = latch[IRQ_W-1:8];
                end
                SS_LAT_LO: ss_rdat = latch[7:0];
                SS_FLAGS:  ss_rdat = {3'b0, ram_on, irq_on, irq_pend, mirror};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bandai_fcg_core.sv
// Directed bench for bandai_fcg_core: one instance per MODE sharing the same bus stimulus.
// Latency: inputs change on rising m2, outputs sampled 1 ns after the falling (active) edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_bandai_fcg_core;

    logic        m2;
    logic        map_rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        cpu_rw;
    logic [13:0] ppu_addr;
    logic        ss_act;
    logic        ss_we;
    logic [7:0]  ss_addr;

    logic [18:0] prg0, prg1, prg2;
    logic [17:0] chr0, chr1, chr2;
    logic        cir0, cir1, cir2;
    logic        rce0, rce1, rce2;
    logic        irq0, irq1, irq2;
    logic [7:0]  rd0, rd1, rd2;

    int n_cmp = 0;
    int n_bad = 0;

    bandai_fcg_core #(.MODE(0), .PRG_W(4), .IRQ_W(16)) u_fcg (
        .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_rw(cpu_rw),
        .ppu_addr(ppu_addr), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
        .prg_addr(prg0), .chr_addr(chr0), .ciram_a10(cir0), .ram_ce(rce0), .irq(irq0), .ss_rdat(rd0)
    );

    bandai_fcg_core #(.MODE(1), .PRG_W(4), .IRQ_W(16)) u_lz (
        .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_rw(cpu_rw),
        .ppu_addr(ppu_addr), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
        .prg_addr(prg1), .chr_addr(chr1), .ciram_a10(cir1), .ram_ce(rce1), .irq(irq1), .ss_rdat(rd1)
    );

    bandai_fcg_core #(.MODE(2), .PRG_W(4), .IRQ_W(16)) u_sram (
        .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .cpu_rw(cpu_rw),
        .ppu_addr(ppu_addr), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
        .prg_addr(prg2), .chr_addr(chr2), .ciram_a10(cir2), .ram_ce(rce2), .irq(irq2), .ss_rdat(rd2)
    );

    initial m2 = 1'b1;
    always #10 m2 = ~m2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One CPU write cycle: drive on rising m2, captured on the following falling edge.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(posedge m2);
        cpu_addr = a;
        cpu_dat  = d;
        cpu_rw   = 1'b0;
        @(negedge m2);
        #1;
        cpu_rw   = 1'b1;
        cpu_addr = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge m2);
        #1;
    endtask

    // Combinational save-state read between edges; ss_act restored afterwards.
    task automatic peek(input string tag, input int inst, input logic [7:0] idx, input logic [7:0] exp);
        logic keep;
        logic [7:0] got;
        keep    = ss_act;
        ss_act  = 1'b1;
        ss_we   = 1'b0;
        ss_addr = idx;
        #1;
        got = (inst == 0) ? rd0 : (inst == 1) ? rd1 : rd2;
        chk(tag, {24'h0, got}, {24'h0, exp});
        ss_act = keep;
    endtask

    initial begin
        map_rst_n = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_dat   = 8'h00;
        cpu_rw    = 1'b1;
        ppu_addr  = 14'h0000;
        ss_act    = 1'b0;
        ss_we     = 1'b0;
        ss_addr   = 8'h00;
        #1;
        chk("rst_irq_lz", {31'h0, irq1}, 32'h0);
        chk("rst_irq_fcg", {31'h0, irq0}, 32'h0);
        peek("rst_flags", 1, 8'd13, 8'h00);
        #3;
        map_rst_n = 1'b1;

        // MODE 1: latch 3, enable -> irq on 4th following falling edge
        wr(16'h800B, 8'h03);
        wr(16'h800C, 8'h00);
        wr(16'h800A, 8'h01);
        peek("lz_ctr_load", 1, 8'd10, 8'h03);
        idle(1); chk("lz_irq_e1", {31'h0, irq1}, 32'h0);
        idle(1); chk("lz_irq_e2", {31'h0, irq1}, 32'h0);
        idle(1); chk("lz_irq_e3", {31'h0, irq1}, 32'h0);
        peek("lz_ctr_zero", 1, 8'd10, 8'h00);
        idle(1); chk("lz_irq_e4", {31'h0, irq1}, 32'h1);
        chk("sram_irq_e4", {31'h0, irq2}, 32'h1);
        chk("fcg_irq_quiet", {31'h0, irq0}, 32'h0);
        wr(16'h800A, 8'h00);
        chk("lz_irq_clr", {31'h0, irq1}, 32'h0);

        // MODE 0: direct load 2, count 2,1,0 then pend and wrap
        wr(16'h600B, 8'h02);
        wr(16'h600C, 8'h00);
        wr(16'h600A, 8'h01);
        peek("fcg_ctr2", 0, 8'd10, 8'h02);
        idle(1); peek("fcg_ctr1", 0, 8'd10, 8'h01);
        idle(1); peek("fcg_ctr0", 0, 8'd10, 8'h00);
        chk("fcg_irq_at0", {31'h0, irq0}, 32'h0);
        idle(1); chk("fcg_irq_set", {31'h0, irq0}, 32'h1);
        peek("fcg_wrap_lo", 0, 8'd10, 8'hFF);
        peek("fcg_wrap_hi", 0, 8'd9, 8'hFF);
        wr(16'h600A, 8'h00);
        chk("fcg_irq_clr", {31'h0, irq0}, 32'h0);

        // MODE 1 precedence: control write on the zero-count edge wins
        wr(16'h800A, 8'h01);
        idle(3);
        peek("prec_ctr0", 1, 8'd10, 8'h00);
        wr(16'h800A, 8'h01);
        chk("prec_irq", {31'h0, irq1}, 32'h0);
        peek("prec_reload", 1, 8'd10, 8'h03);
        wr(16'h800A, 8'h00);

        // MODE 0 byte write while counting: no decrement, other byte holds
        wr(16'h600C, 8'h12);
        wr(16'h600B, 8'h01);
        wr(16'h600A, 8'h01);
        idle(1);
        peek("byte_pre", 0, 8'd10, 8'h00);
        wr(16'h600B, 8'h80);
        peek("byte_lo", 0, 8'd10, 8'h80);
        peek("byte_hi", 0, 8'd9, 8'h12);
        idle(1);
        peek("byte_next", 0, 8'd10, 8'h7F);
        wr(16'h600A, 8'h00);

        // MODE 2 banking, RAM enable, mirroring; MODE 1 for contrast
        wr(16'h8002, 8'h01);
        wr(16'h8008, 8'h05);
        cpu_addr = 16'h8000; #1;
        chk("sram_prg_8000", {27'h0, prg2[18:14]}, 32'h15);
        chk("lz_prg_8000", {27'h0, prg1[18:14]}, 32'h05);
        cpu_addr = 16'hC000; #1;
        chk("sram_prg_c000", {27'h0, prg2[18:14]}, 32'h1F);
        chk("lz_prg_c000", {27'h0, prg1[18:14]}, 32'h0F);
        cpu_addr = 16'h0000;
        wr(16'h800D, 8'h20);
        cpu_addr = 16'h6000; #1;
        chk("sram_ramce", {31'h0, rce2}, 32'h1);
        chk("lz_ramce", {31'h0, rce1}, 32'h0);
        cpu_addr = 16'h8000; #1;
        chk("sram_ramce_off", {31'h0, rce2}, 32'h0);
        cpu_addr = 16'h0000;
        wr(16'h8009, 8'h01);
        ppu_addr = 14'h0800; #1;
        chk("mir_h_hi", {31'h0, cir2}, 32'h1);
        chk("lz_chr", {14'h0, chr1}, 32'h00400);
        chk("sram_chr", {14'h0, chr2}, 32'h00800);
        ppu_addr = 14'h0400; #1;
        chk("mir_h_lo", {31'h0, cir2}, 32'h0);
        wr(16'h8009, 8'h03);
        ppu_addr = 14'h0000; #1;
        chk("mir_one", {31'h0, cir1}, 32'h1);
        wr(16'h8009, 8'h02);
        ppu_addr = 14'h0C00; #1;
        chk("mir_zero", {31'h0, cir1}, 32'h0);
        ppu_addr = 14'h0000;

        // Save state: write flags and counter high byte, counting frozen
        @(posedge m2);
        ss_act = 1'b1; ss_we = 1'b1; ss_addr = 8'd13; cpu_dat = 8'h1C;
        @(posedge m2);
        ss_addr = 8'd9; cpu_dat = 8'h12;
        @(negedge m2); #1;
        ss_we = 1'b0;
        idle(2);
        peek("ss_flags_lz", 1, 8'd13, 8'h1C);
        peek("ss_flags_fcg", 0, 8'd13, 8'h1C);
        peek("ss_ctr_hi", 1, 8'd9, 8'h12);
        peek("ss_frozen", 1, 8'd10, 8'h03);
        peek("ss_unmapped", 1, 8'd200, 8'hFF);
        chk("ss_irq", {31'h0, irq1}, 32'h1);
        ss_act = 1'b0;

        // Counting resumes, then async reset between edges
        idle(2);
        peek("resume", 1, 8'd10, 8'h01);
        map_rst_n = 1'b0;
        cpu_addr = 16'h8000;
        #1;
        chk("arst_irq_lz", {31'h0, irq1}, 32'h0);
        chk("arst_irq_sram", {31'h0, irq2}, 32'h0);
        chk("arst_prg", {27'h0, prg2[18:14]}, 32'h00);
        peek("arst_ctr", 1, 8'd10, 8'h00);
        peek("arst_chr2", 1, 8'd2, 8'h00);
        peek("arst_flags", 2, 8'd13, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
